// File: rtl/display_source_switch_pkg.sv
// Shared types and defaults for the frame-aligned display source selector.
package display_source_switch_pkg;

  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    S_STABLE   = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_PENDING  = 2'd2
  } sel_state_e;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_t;

  // LSB of lane idx inside a packed multi-source colour bus
  function automatic int unsigned lane_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/display_source_switch_sel_debounce.sv
// Switch synchroniser, debouncer and vsync-aligned commit of the active source.
module display_source_switch_sel_debounce
  import display_source_switch_pkg::*;
#(
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned DEB_CYCLES = 500000,
  parameter int unsigned RESET_SEL  = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [SEL_W-1:0] i_sel_req,
  input  logic             i_vs_rise,
  output logic [SEL_W-1:0] o_sel_active,
  output logic             o_commit_c,
  output logic [SEL_W-1:0] o_sel_next_c
);

  localparam int unsigned      CNT_W    = $clog2(DEB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [SEL_W-1:0] SEL_RST  = SEL_W'(RESET_SEL);

  logic [SEL_W-1:0] r_sync1;
  logic [SEL_W-1:0] r_sync2;
  sel_state_e       r_state;
  logic [SEL_W-1:0] r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_sel_active;

  sel_state_e       w_state_nx;
  logic [SEL_W-1:0] w_cand_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [SEL_W-1:0] w_sel_nx;
  logic             w_commit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1      <= SEL_RST;
      r_sync2      <= SEL_RST;
      r_state      <= S_STABLE;
      r_cand       <= SEL_RST;
      r_cnt        <= '0;
      r_sel_active <= SEL_RST;
    end else begin
      r_sync1      <= i_sel_req;
      r_sync2      <= r_sync1;
      r_state      <= w_state_nx;
      r_cand       <= w_cand_nx;
      r_cnt        <= w_cnt_nx;
      r_sel_active <= w_sel_nx;
    end
  end

  // A request falling back to the shown source is dropped rather than re-committed
  always_comb begin
    w_state_nx = r_state;
    w_cand_nx  = r_cand;
    w_cnt_nx   = r_cnt;
    w_sel_nx   = r_sel_active;
    w_commit   = 1'b0;
    case (r_state)
      S_STABLE: begin
        if (r_sync2 != r_sel_active) begin
          w_cand_nx  = r_sync2;
          w_cnt_nx   = '0;
          w_state_nx = S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (r_sync2 != r_cand) begin
          w_cand_nx = r_sync2;
          w_cnt_nx  = '0;
          if (r_sync2 == r_sel_active) w_state_nx = S_STABLE;
        end else begin
          if (r_cnt != CNT_MAX) w_cnt_nx = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) w_state_nx = S_PENDING;
        end
      end
      S_PENDING: begin
        if (r_sync2 != r_cand) begin
          w_cand_nx  = r_sync2;
          w_cnt_nx   = '0;
          w_state_nx = (r_sync2 == r_sel_active) ? S_STABLE : S_DEBOUNCE;
        end else if (i_vs_rise) begin
          w_commit   = 1'b1;
          w_sel_nx   = r_cand;
          w_state_nx = S_STABLE;
        end
      end
      default: w_state_nx = S_STABLE;
    endcase
  end

  assign o_sel_active = r_sel_active;
  assign o_commit_c   = w_commit;
  assign o_sel_next_c = w_sel_nx;

endmodule

// File: rtl/display_source_switch.sv
// Two-stage registered video source mux; source changes land on a vsync rise.
module display_source_switch
  import display_source_switch_pkg::*;
#(
  parameter int unsigned            DATA_W     = DEF_DATA_W,
  parameter int unsigned            NUM_SRC    = 4,
  parameter int unsigned            SEL_W      = 2,
  parameter logic [(1<<SEL_W)-1:0]  MONO_MASK  = 4'b0110,
  parameter int unsigned            DEB_CYCLES = 500000,
  parameter int unsigned            RESET_SEL  = 0,
  parameter bit                     BLANK_SW   = 1'b1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [SEL_W-1:0]          i_sel_req,
  input  logic [NUM_SRC*DATA_W-1:0] i_src_r,
  input  logic [NUM_SRC*DATA_W-1:0] i_src_g,
  input  logic [NUM_SRC*DATA_W-1:0] i_src_b,
  input  logic                      i_hsync,
  input  logic                      i_vsync,
  input  logic                      i_de,
  output logic [DATA_W-1:0]         o_r,
  output logic [DATA_W-1:0]         o_g,
  output logic [DATA_W-1:0]         o_b,
  output logic                      o_hsync,
  output logic                      o_vsync,
  output logic                      o_de,
  output logic [SEL_W-1:0]          o_sel_active
);

  localparam int unsigned LANE_W = NUM_SRC * DATA_W;
  localparam int unsigned LANES  = 1 << SEL_W;

  logic [LANE_W-1:0] r_s1_r;
  logic [LANE_W-1:0] r_s1_g;
  logic [LANE_W-1:0] r_s1_b;
  sync_t             r_s1_sync;
  sync_t             r_s2_sync;
  logic              r_blank;
  logic [DATA_W-1:0] r_out_r;
  logic [DATA_W-1:0] r_out_g;
  logic [DATA_W-1:0] r_out_b;

  logic              w_vs_rise;
  logic              w_commit;
  logic [SEL_W-1:0]  w_sel_nx;
  logic              w_blank_nx;
  logic              w_sel_ok;
  logic [DATA_W-1:0] w_pix_r;
  logic [DATA_W-1:0] w_pix_g;
  logic [DATA_W-1:0] w_pix_b;
  logic [DATA_W-1:0] w_lane_r [LANES];
  logic [DATA_W-1:0] w_lane_g [LANES];
  logic [DATA_W-1:0] w_lane_b [LANES];

  // Stage-2 vsync doubles as the "previous" sample for the stage-1 edge detect
  assign w_vs_rise = r_s1_sync.vsync & ~r_s2_sync.vsync;

  display_source_switch_sel_debounce #(
    .SEL_W      (SEL_W),
    .DEB_CYCLES (DEB_CYCLES),
    .RESET_SEL  (RESET_SEL)
  ) u_sel_debounce (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_sel_req    (i_sel_req),
    .i_vs_rise    (w_vs_rise),
    .o_sel_active (o_sel_active),
    .o_commit_c   (w_commit),
    .o_sel_next_c (w_sel_nx)
  );

  // Select codes beyond NUM_SRC read an all-zero lane
  for (genvar gi = 0; gi < int'(LANES); gi++) begin : g_lane
    if (gi < int'(NUM_SRC)) begin : g_src
      assign w_lane_r[gi] = r_s1_r[lane_lsb(gi, DATA_W) +: DATA_W];
      assign w_lane_g[gi] = r_s1_g[lane_lsb(gi, DATA_W) +: DATA_W];
      assign w_lane_b[gi] = r_s1_b[lane_lsb(gi, DATA_W) +: DATA_W];
    end else begin : g_pad
      assign w_lane_r[gi] = '0;
      assign w_lane_g[gi] = '0;
      assign w_lane_b[gi] = '0;
    end
  end

  always_comb begin
    w_blank_nx = r_blank;
    if (w_vs_rise) w_blank_nx = w_commit & BLANK_SW;
  end

  assign w_sel_ok = (32'(w_sel_nx) < NUM_SRC);

  // Uses next-cycle select/blank so the first pixel of a new frame is already switched
  always_comb begin
    w_pix_r = '0;
    w_pix_g = '0;
    w_pix_b = '0;
    if (r_s1_sync.de && !w_blank_nx && w_sel_ok) begin
      w_pix_r = w_lane_r[w_sel_nx];
      if (MONO_MASK[w_sel_nx]) begin
        w_pix_g = w_lane_r[w_sel_nx];
        w_pix_b = w_lane_r[w_sel_nx];
      end else begin
        w_pix_g = w_lane_g[w_sel_nx];
        w_pix_b = w_lane_b[w_sel_nx];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_r    <= '0;
      r_s1_g    <= '0;
      r_s1_b    <= '0;
      r_s1_sync <= '0;
      r_s2_sync <= '0;
      r_blank   <= 1'b0;
      r_out_r   <= '0;
      r_out_g   <= '0;
      r_out_b   <= '0;
    end else begin
      r_s1_r    <= i_src_r;
      r_s1_g    <= i_src_g;
      r_s1_b    <= i_src_b;
      r_s1_sync <= '{hsync: i_hsync, vsync: i_vsync, de: i_de};
      r_s2_sync <= r_s1_sync;
      r_blank   <= w_blank_nx;
      r_out_r   <= w_pix_r;
      r_out_g   <= w_pix_g;
      r_out_b   <= w_pix_b;
    end
  end

  assign o_r     = r_out_r;
  assign o_g     = r_out_g;
  assign o_b     = r_out_b;
  assign o_hsync = r_s2_sync.hsync;
  assign o_vsync = r_s2_sync.vsync;
  assign o_de    = r_s2_sync.de;

endmodule

// File: tb/tb_display_source_switch.sv
// Bench for display_source_switch: 4-source and 3-source instances against a frame-level model.
module tb_display_source_switch;

  localparam int unsigned DEB   = 4;
  localparam int          FRAME = 24;
  localparam logic [3:0]  MONO  = 4'b0110;

  typedef struct packed {
    logic [1:0]      req;
    logic            hs;
    logic            vs;
    logic            de;
    logic [3:0][7:0] r;
    logic [3:0][7:0] g;
    logic [3:0][7:0] b;
  } in_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [1:0]      req = 2'd0;
  logic            hs = 1'b0, vs = 1'b0, de = 1'b0;
  logic [3:0][7:0] lr = '0, lg = '0, lb = '0;

  logic [7:0] r4, g4, b4, r3, g3, b3;
  logic       hs4, vs4, de4, hs3, vs3, de3;
  logic [1:0] sel4, sel3;
  logic [28:0] got4, got3;

  in_t         hist [4096];
  int          n = 0;
  logic [1:0]  m_active = 2'd0;
  bit          m_blank = 1'b0;
  logic [28:0] exp4 = '0, exp3 = '0;
  int          ncmp = 0;
  int          nfail = 0;

  always #5 clk = ~clk;

  assign got4 = {r4, g4, b4, hs4, vs4, de4, sel4};
  assign got3 = {r3, g3, b3, hs3, vs3, de3, sel3};

  display_source_switch #(
    .DATA_W(8), .NUM_SRC(4), .SEL_W(2), .MONO_MASK(4'b0110),
    .DEB_CYCLES(DEB), .RESET_SEL(0), .BLANK_SW(1'b1)
  ) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_sel_req(req),
    .i_src_r(lr), .i_src_g(lg), .i_src_b(lb),
    .i_hsync(hs), .i_vsync(vs), .i_de(de),
    .o_r(r4), .o_g(g4), .o_b(b4),
    .o_hsync(hs4), .o_vsync(vs4), .o_de(de4), .o_sel_active(sel4)
  );

  display_source_switch #(
    .DATA_W(8), .NUM_SRC(3), .SEL_W(2), .MONO_MASK(4'b0110),
    .DEB_CYCLES(DEB), .RESET_SEL(0), .BLANK_SW(1'b1)
  ) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_sel_req(req),
    .i_src_r(lr[2:0]), .i_src_g(lg[2:0]), .i_src_b(lb[2:0]),
    .i_hsync(hs), .i_vsync(vs), .i_de(de),
    .o_r(r3), .o_g(g3), .o_b(b3),
    .o_hsync(hs3), .o_vsync(vs3), .o_de(de3), .o_sel_active(sel3)
  );

  // Before reset release the switches read as RESET_SEL (0) and the sync lines are idle
  function automatic in_t hget(input int idx);
    in_t z;
    z = '0;
    if (idx < 0) return z;
    return hist[idx];
  endfunction

  function automatic logic [28:0] model_out(input in_t p, input int nsrc,
                                            input logic [1:0] act, input bit blank);
    logic [7:0] r, g, b;
    r = '0; g = '0; b = '0;
    if (p.de && !blank && int'(act) < nsrc) begin
      r = p.r[act];
      g = MONO[act] ? p.r[act] : p.g[act];
      b = MONO[act] ? p.r[act] : p.b[act];
    end
    return {r, g, b, p.hs, p.vs, p.de, act};
  endfunction

  // One clock: a switch to a new source happens at a vsync rise once the synchronised
  // switch value has held for DEB+2 consecutive cycles; the frame after it is black.
  task automatic tick();
    in_t p1, p2, q;
    logic [1:0] s;
    bit stable, vr;
    hist[n] = {req, hs, vs, de, lr, lg, lb};
    @(posedge clk);
    #1;
    p1 = hget(n - 1);
    p2 = hget(n - 2);
    s  = p2.req;
    vr = p1.vs && !p2.vs;
    stable = 1'b1;
    for (int j = 0; j <= int'(DEB) + 1; j++) begin
      q = hget(n - 2 - j);
      if (q.req != s) stable = 1'b0;
    end
    if (vr) begin
      if (stable && s != m_active) begin
        m_active = s;
        m_blank  = 1'b1;
      end else begin
        m_blank = 1'b0;
      end
    end
    exp4 = model_out(p1, 4, m_active, m_blank);
    exp3 = model_out(p1, 3, m_active, m_blank);
    n++;
  endtask

  task automatic rand_lanes();
    for (int i = 0; i < 4; i++) begin
      lr[i] = 8'($urandom);
      lg[i] = 8'($urandom);
      lb[i] = 8'($urandom);
    end
  endtask

  task automatic drive_frame(input int c);
    int p;
    p  = c % FRAME;
    vs = (p < 2);
    hs = (p % 8 == 0);
    de = (p >= 4) && (p % 8 >= 2);
    rand_lanes();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
  endtask

  task automatic do_release();
    @(posedge clk);
    #1 rst = 1'b0;
    n = 0; m_active = 2'd0; m_blank = 1'b0; exp4 = '0; exp3 = '0;
  endtask

  task automatic test_reset();
    int first_c;
    do_reset();
    ncmp++; if (got4 !== 29'd0) begin nfail++; $display("FAIL por_state4 got=%h exp=%h", got4, 29'd0); end
    do_release();
    req = 2'd0;
    for (int c = 0; c < FRAME + 10; c++) begin
      if (c == FRAME + 3) req = 2'd2;
      drive_frame(c); tick();
      ncmp++; if (got4 !== exp4) begin nfail++; $display("FAIL pre_rst4 n=%0d got=%h exp=%h", n, got4, exp4); end
    end
    do_reset();
    ncmp++; if (got4 !== 29'd0) begin nfail++; $display("FAIL midrst4 got=%h exp=%h", got4, 29'd0); end
    ncmp++; if (got3 !== 29'd0) begin nfail++; $display("FAIL midrst3 got=%h exp=%h", got3, 29'd0); end
    do_release();
    first_c = -1;
    for (int c = 0; c < 3 * FRAME; c++) begin
      drive_frame(c); tick();
      if (first_c < 0 && sel4 == 2'd2) first_c = c;
      ncmp++; if (got4 !== exp4) begin nfail++; $display("FAIL post_rst4 n=%0d got=%h exp=%h", n, got4, exp4); end
    end
    ncmp++; if (first_c !== FRAME + 1) begin nfail++; $display("FAIL rst_commit_cycle got=%0d exp=%0d", first_c, FRAME + 1); end
  endtask

  task automatic test_passthrough();
    do_reset(); do_release();
    req = 2'd0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      drive_frame(c);
      lr[0] = 8'd10; lg[0] = 8'd20; lb[0] = 8'd30;
      tick();
      ncmp++; if (got4 !== exp4) begin nfail++; $display("FAIL pass4 n=%0d got=%h exp=%h", n, got4, exp4); end
      ncmp++; if (got3 !== exp3) begin nfail++; $display("FAIL pass3 n=%0d got=%h exp=%h", n, got3, exp3); end
      if (de4) begin
        ncmp++;
        if ({r4, g4, b4} !== {8'd10, 8'd20, 8'd30}) begin
          nfail++; $display("FAIL pass_rgb got=%h exp=%h", {r4, g4, b4}, {8'd10, 8'd20, 8'd30});
        end
      end
    end
  endtask

  task automatic test_mono_switch();
    do_reset(); do_release();
    req = 2'd0;
    for (int c = 0; c < 3 * FRAME; c++) begin
      if (c == 3) req = 2'd1;
      drive_frame(c);
      lr[1] = 8'h55;
      tick();
      ncmp++; if (got4 !== exp4) begin nfail++; $display("FAIL mono4 n=%0d got=%h exp=%h", n, got4, exp4); end
      if (c >= FRAME + 1 && c <= 2 * FRAME && de4) begin
        ncmp++; if ({r4, g4, b4} !== 24'h0) begin nfail++; $display("FAIL blank_frame got=%h exp=%h", {r4, g4, b4}, 24'h0); end
      end
      if (c > 2 * FRAME && de4) begin
        ncmp++; if ({r4, g4, b4} !== 24'h555555) begin nfail++; $display("FAIL mono_rgb got=%h exp=%h", {r4, g4, b4}, 24'h555555); end
      end
    end
    ncmp++; if (sel4 !== 2'd1) begin nfail++; $display("FAIL mono_sel got=%0d exp=1", sel4); end
  endtask

  task automatic test_toggle();
    do_reset(); do_release();
    for (int c = 0; c < 3 * FRAME + 4; c++) begin
      req = ((c / 2) % 2 == 1) ? 2'd2 : 2'd1;
      drive_frame(c); tick();
      ncmp++; if (got4 !== exp4) begin nfail++; $display("FAIL toggle4 n=%0d got=%h exp=%h", n, got4, exp4); end
    end
    ncmp++; if (sel4 !== 2'd0) begin nfail++; $display("FAIL toggle_sel got=%0d exp=0", sel4); end
  endtask

  task automatic test_same_cycle();
    do_reset(); do_release();
    req = 2'd0; hs = 1'b0;
    for (int c = 0; c < 46; c++) begin
      if (c == 4) req = 2'd2;
      vs = (c == 9 || c == 10 || c == 33 || c == 34);
      de = (c % 3 != 0);
      rand_lanes();
      tick();
      ncmp++; if (got4 !== exp4) begin nfail++; $display("FAIL same4 n=%0d got=%h exp=%h", n, got4, exp4); end
      if (c == 33) begin
        ncmp++; if (sel4 !== 2'd0) begin nfail++; $display("FAIL same_early got=%0d exp=0", sel4); end
      end
      if (c == 34) begin
        ncmp++; if (sel4 !== 2'd2) begin nfail++; $display("FAIL same_late got=%0d exp=2", sel4); end
      end
    end
  endtask

  task automatic test_num_src3();
    do_reset(); do_release();
    req = 2'd3;
    for (int c = 0; c < 3 * FRAME; c++) begin
      drive_frame(c); tick();
      ncmp++; if (got3 !== exp3) begin nfail++; $display("FAIL ns3 n=%0d got=%h exp=%h", n, got3, exp3); end
      ncmp++; if (got4 !== exp4) begin nfail++; $display("FAIL ns3_4 n=%0d got=%h exp=%h", n, got4, exp4); end
      if (c > 2 * FRAME && de3) begin
        ncmp++; if ({r3, g3, b3} !== 24'h0) begin nfail++; $display("FAIL ns3_rgb got=%h exp=%h", {r3, g3, b3}, 24'h0); end
      end
    end
    ncmp++; if (sel3 !== 2'd3) begin nfail++; $display("FAIL ns3_sel got=%0d exp=3", sel3); end
    for (int c = 0; c < FRAME; c++) begin
      drive_frame(c);
      de  = 1'b0;
      req = 2'($urandom_range(0, 3));
      tick();
      if (c >= 2) begin
        ncmp++;
        if ({r4, g4, b4, r3, g3, b3} !== 48'h0) begin
          nfail++; $display("FAIL de_low got=%h exp=%h", {r4, g4, b4, r3, g3, b3}, 48'h0);
        end
      end
    end
  endtask

  task automatic test_random();
    int hold, fpos, flen;
    do_reset(); do_release();
    hold = 0; fpos = 0; flen = 16;
    for (int c = 0; c < 700; c++) begin
      if (hold == 0) begin
        req  = 2'($urandom_range(0, 3));
        hold = int'($urandom_range(1, 10));
      end
      hold--;
      if (fpos == 0) flen = int'($urandom_range(8, 30));
      vs = (fpos < 2);
      hs = (fpos % 6 == 0);
      de = (fpos >= 3) && ($urandom_range(0, 3) != 0);
      rand_lanes();
      fpos = (fpos + 1 == flen) ? 0 : fpos + 1;
      tick();
      ncmp++; if (got4 !== exp4) begin nfail++; $display("FAIL rand4 n=%0d got=%h exp=%h", n, got4, exp4); end
      ncmp++; if (got3 !== exp3) begin nfail++; $display("FAIL rand3 n=%0d got=%h exp=%h", n, got3, exp3); end
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    test_reset();
    test_passthrough();
    test_mono_switch();
    test_toggle();
    test_same_cycle();
    test_num_src3();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
